// File: rtl/source_a_req_queue.sv
// Request queue between the L2 scheduler and the SourceA stage.
// Buffers packed memory requests in a small circular FIFO and throttles
// issue so that no more than MAX_OUTSTANDING requests are in flight to main
// memory; D-channel retirements (d_fire_i) free up in-flight slots.
`timescale 1ns/1ps

module source_a_req_queue #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TAG_BITS        = 8,
    parameter int SET_BITS        = 4,
    parameter int OFFSET_BITS     = 4,
    parameter int OP_BITS         = 3,
    parameter int SIZE_BITS       = 3,
    parameter int SOURCE_BITS     = 4,
    parameter int MASK_BITS       = 4,
    parameter int DATA_BITS       = 32,
    // Packing MSB..LSB: {tag, set, offset, opcode, size, source, mask, data}
    localparam int PAYLOAD_BITS   = TAG_BITS + SET_BITS + OFFSET_BITS + OP_BITS
                                  + SIZE_BITS + SOURCE_BITS + MASK_BITS + DATA_BITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enq_valid_i,
    output logic                    enq_ready_o,
    input  logic [PAYLOAD_BITS-1:0] enq_payload_i,
    output logic                    deq_valid_o,
    input  logic                    deq_ready_i,
    output logic [PAYLOAD_BITS-1:0] deq_payload_o,
    input  logic                    d_fire_i,
    output logic [7:0]              outstanding_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    underflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Storage is intentionally not reset; the payload is only meaningful
    // while deq_valid_o is high.
    logic [PAYLOAD_BITS-1:0] r_mem [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_outstanding;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_enq_fire;
    logic             w_deq_fire;
    logic             w_deq_valid;
    logic [CNT_W-1:0] w_count_next;
    logic [7:0]       w_outstanding_next;
    logic             w_underflow_next;

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    // Issue is gated by the in-flight limit so outstanding never exceeds it.
    assign w_deq_valid = !w_empty && (r_outstanding < 8'(MAX_OUTSTANDING));
    // Full means no slot, even if a dequeue happens this cycle.
    assign w_enq_fire  = enq_valid_i && !w_full;
    assign w_deq_fire  = w_deq_valid && deq_ready_i;

    assign enq_ready_o   = !w_full;
    assign deq_valid_o   = w_deq_valid;
    assign deq_payload_o = r_mem[r_rd_ptr];
    assign outstanding_o = r_outstanding;
    assign full_o        = w_full;
    assign empty_o       = w_empty;
    assign underflow_o   = r_underflow;

    // Next-state for entry count, in-flight count and the sticky underflow flag.
    always_comb begin
        w_count_next       = r_count;
        w_outstanding_next = r_outstanding;
        w_underflow_next   = r_underflow;

        if (w_enq_fire && !w_deq_fire) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_enq_fire && w_deq_fire) begin
            w_count_next = r_count - CNT_W'(1);
        end

        if (d_fire_i && (r_outstanding == 8'd0)) begin
            w_underflow_next = 1'b1;
        end

        if (w_deq_fire && !d_fire_i) begin
            w_outstanding_next = r_outstanding + 8'd1;
        end else if (!w_deq_fire && d_fire_i && (r_outstanding != 8'd0)) begin
            w_outstanding_next = r_outstanding - 8'd1;
        end
    end

    // Payload write into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (w_enq_fire) begin
            r_mem[r_wr_ptr] <= enq_payload_i;
        end
    end

    // Pointer, count and in-flight state; pointers wrap naturally (power of 2).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= 8'd0;
            r_underflow   <= 1'b0;
        end else begin
            if (w_enq_fire) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq_fire) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count       <= w_count_next;
            r_outstanding <= w_outstanding_next;
            r_underflow   <= w_underflow_next;
        end
    end

endmodule

// File: tb/tb_source_a_req_queue.sv
// Testbench for source_a_req_queue: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps

module tb_source_a_req_queue;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;
    localparam int PW    = 8 + 4 + 4 + 3 + 3 + 4 + 4 + 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enq_valid_i = 1'b0;
    logic          enq_ready_o;
    logic [PW-1:0] enq_payload_i = '0;
    logic          deq_valid_o;
    logic          deq_ready_i = 1'b0;
    logic [PW-1:0] deq_payload_o;
    logic          d_fire_man = 1'b0;
    logic          auto_pulse = 1'b0;
    logic          auto_dfire = 1'b0;
    logic          d_fire_w;
    logic [7:0]    outstanding_o;
    logic          full_o;
    logic          empty_o;
    logic          underflow_o;

    assign d_fire_w = d_fire_man | auto_pulse;

    source_a_req_queue #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enq_valid_i   (enq_valid_i),
        .enq_ready_o   (enq_ready_o),
        .enq_payload_i (enq_payload_i),
        .deq_valid_o   (deq_valid_o),
        .deq_ready_i   (deq_ready_i),
        .deq_payload_o (deq_payload_o),
        .d_fire_i      (d_fire_w),
        .outstanding_o (outstanding_o),
        .full_o        (full_o),
        .empty_o       (empty_o),
        .underflow_o   (underflow_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Distinct values in every field so the whole payload is checked bit-exact.
    function automatic logic [PW-1:0] mk(input int d);
        return {8'(d * 3 + 1), 4'(d), 4'(d + 5), 3'(d), 3'(d + 1),
                4'(d + 2), 4'(d + 9), 32'hDEAD0000 | 32'(d)};
    endfunction

    // Reference model: FIFO contents as a queue, in-flight count as an integer.
    logic [PW-1:0] m_q[$];
    int            m_out = 0;
    bit            m_under = 1'b0;
    bit            m_ef, m_df, m_ev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_out   = 0;
            m_under = 1'b0;
        end else begin
            m_df = deq_ready_i && (m_q.size() > 0) && (m_out < MAXO);
            m_ef = enq_valid_i && (m_q.size() < DEPTH);
            if (m_df) void'(m_q.pop_front());
            if (m_ef) m_q.push_back(enq_payload_i);
            if (d_fire_w && m_out == 0) m_under = 1'b1;
            if (m_df && !d_fire_w) m_out++;
            else if (!m_df && d_fire_w && m_out > 0) m_out--;
        end
    end

    // Memory responder: retires one request per cycle while any are in flight.
    always @(posedge clk) begin
        #1;
        auto_pulse = auto_dfire && (m_out > 0);
    end

    // Observed issue order, taken at each dequeue handshake.
    logic [PW-1:0] obs[$];
    always @(posedge clk) begin
        if (rst_n && deq_valid_o && deq_ready_i) obs.push_back(deq_payload_o);
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            m_ev = (m_q.size() > 0) && (m_out < MAXO);
            chk("enq_ready", enq_ready_o, m_q.size() < DEPTH);
            chk("deq_valid", deq_valid_o, m_ev);
            if (m_ev) chk("deq_payload", deq_payload_o, m_q[0]);
            chk("outstanding", outstanding_o, m_out);
            chk("full", full_o, m_q.size() == DEPTH);
            chk("empty", empty_o, m_q.size() == 0);
            chk("underflow", underflow_o, m_under);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    int base;
    int exp2[10] = '{17, 18, 19, 20, 33, 34, 35, 36, 37, 38};

    initial begin
        // Reset state held while rst_n is low
        repeat (3) tick();
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_enq_ready", enq_ready_o, 1);
        chk("rst_deq_valid", deq_valid_o, 0);
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_underflow", underflow_o, 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Four enqueues, drained in order, first offer one cycle after first enq
        auto_dfire  = 1'b1;
        deq_ready_i = 1'b1;
        base = obs.size();
        chk("t1_pre_valid", deq_valid_o, 0);
        for (int i = 1; i <= 4; i++) begin
            enq_valid_i   = 1'b1;
            enq_payload_i = mk(i);
            tick();
            if (i == 1) chk("t1_first_deq_valid", deq_valid_o, 1);
        end
        enq_valid_i = 1'b0;
        repeat (6) tick();
        chk("t1_count", obs.size() - base, 4);
        for (int k = 0; k < 4; k++) chk("t1_order", obs[base + k], mk(k + 1));
        auto_dfire = 1'b0;
        repeat (2) tick();
        chk("t1_out_idle", outstanding_o, 0);

        // Fill to full with a fifth held off, drain, refill 6 across the wrap
        deq_ready_i = 1'b0;
        base = obs.size();
        for (int i = 1; i <= 5; i++) begin
            enq_valid_i   = 1'b1;
            enq_payload_i = mk(16 + i);
            tick();
            if (i == 4) begin
                chk("t2_full", full_o, 1);
                chk("t2_enq_ready", enq_ready_o, 0);
            end
        end
        chk("t2_full_held", full_o, 1);
        chk("t2_head", deq_payload_o, mk(17));
        repeat (2) tick();
        chk("t2_still_full", full_o, 1);
        enq_valid_i = 1'b0;
        auto_dfire  = 1'b1;
        deq_ready_i = 1'b1;
        for (int n = 0; n < 30 && !empty_o; n++) tick();
        chk("t2_drained", empty_o, 1);
        for (int i = 1; i <= 6; i++) begin
            enq_valid_i   = 1'b1;
            enq_payload_i = mk(32 + i);
            tick();
        end
        enq_valid_i = 1'b0;
        repeat (8) tick();
        chk("t2_count", obs.size() - base, 10);
        for (int k = 0; k < 10; k++) chk("t2_order", obs[base + k], mk(exp2[k]));
        auto_dfire = 1'b0;
        repeat (3) tick();
        chk("t2_out_idle", outstanding_o, 0);

        // In-flight limit of 2 blocks the third issue until one retirement
        deq_ready_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            enq_valid_i   = 1'b1;
            enq_payload_i = mk(48 + i);
            tick();
        end
        enq_valid_i = 1'b0;
        deq_ready_i = 1'b1;
        repeat (2) tick();
        chk("t3_out_limit", outstanding_o, 2);
        chk("t3_valid_blocked", deq_valid_o, 0);
        chk("t3_not_empty", empty_o, 0);
        tick();
        chk("t3_still_blocked", deq_valid_o, 0);
        d_fire_man = 1'b1;
        tick();
        d_fire_man = 1'b0;
        chk("t3_out_after_d", outstanding_o, 1);
        chk("t3_valid_again", deq_valid_o, 1);
        chk("t3_third_head", deq_payload_o, mk(51));
        tick();
        chk("t3_out_refill", outstanding_o, 2);
        chk("t3_empty", empty_o, 1);

        // Simultaneous issue and retirement; retirement at zero sets underflow
        d_fire_man = 1'b1;
        tick();
        d_fire_man = 1'b0;
        chk("t4_out_one", outstanding_o, 1);
        enq_valid_i   = 1'b1;
        enq_payload_i = mk(64);
        tick();
        enq_valid_i = 1'b0;
        chk("t4_valid", deq_valid_o, 1);
        d_fire_man = 1'b1;
        tick();
        d_fire_man = 1'b0;
        chk("t4_same_cycle_out", outstanding_o, 1);
        chk("t4_issued", empty_o, 1);
        chk("t4_no_underflow", underflow_o, 0);
        d_fire_man = 1'b1;
        tick();
        chk("t4_out_zero", outstanding_o, 0);
        tick();
        d_fire_man = 1'b0;
        chk("t4_underflow_out", outstanding_o, 0);
        chk("t4_underflow", underflow_o, 1);
        tick();
        chk("t4_underflow_sticky", underflow_o, 1);

        // Reset mid-stream with 3 queued and 2 in flight
        enq_valid_i   = 1'b1;
        enq_payload_i = mk(80);
        tick();
        enq_payload_i = mk(81);
        tick();
        enq_valid_i = 1'b0;
        tick();
        deq_ready_i = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            enq_valid_i   = 1'b1;
            enq_payload_i = mk(80 + i);
            tick();
        end
        enq_valid_i = 1'b0;
        chk("t5_out_pre", outstanding_o, 2);
        chk("t5_not_empty", empty_o, 0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_empty", empty_o, 1);
        chk("t5_rst_out", outstanding_o, 0);
        chk("t5_rst_valid", deq_valid_o, 0);
        chk("t5_rst_underflow", underflow_o, 0);
        chk("t5_rst_full", full_o, 0);
        chk("t5_rst_enq_ready", enq_ready_o, 1);
        repeat (2) tick();
        rst_n = 1'b1;

        // Enq on first edge after reset; head stays stable while stalled
        enq_valid_i   = 1'b1;
        enq_payload_i = mk(96);
        tick();
        chk("t6_first_enq", empty_o, 0);
        enq_payload_i = mk(97);
        tick();
        enq_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_valid", deq_valid_o, 1);
            chk("t6_stable", deq_payload_o, mk(96));
        end
        deq_ready_i = 1'b1;
        auto_dfire  = 1'b1;
        repeat (6) tick();
        chk("t6_drained", empty_o, 1);
        auto_dfire  = 1'b0;
        deq_ready_i = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
